// File: rtl/elastic_async_operator.sv
// elastic_async_operator: dataflow operator node. It gathers input_size
// operands over per-operand req/ack handshakes, applies op, queues results in a
// depth-entry FIFO, and fans each result out to output_size consumers. Each
// consumer has its own one-cycle acknowledge.
// Optional feature macro: ELASTIC_OP_STATS_EN adds the fire_cnt/stall_cnt
// statistics outputs.

// One operand slot. It requests an operand, captures it on ack_l, and holds it
// until the node fires.
module elastic_async_operator_slot #(
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ack_l,
  input  logic [data_width-1:0] din,
  input  logic                  fire,
  output logic                  req_l,
  output logic                  has,
  output logic [data_width-1:0] opnd
);
  // Request when empty, capture on ack, release on fire (ack ignored while full)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_l <= 1'b0;
      has   <= 1'b0;
      opnd  <= '0;
    end else if (fire) begin
      has <= 1'b0;
    end else if (!has) begin
      if (ack_l) begin
        opnd  <= din;
        has   <= 1'b1;
        req_l <= 1'b0;
      end else if (!req_l) begin
        req_l <= 1'b1;
      end
    end
  end
endmodule

// One consumer port. It issues one ack per FIFO entry and never asserts ack on
// two cycles in a row.
module elastic_async_operator_port (
  input  logic clk,
  input  logic rst,
  input  logic avail,
  input  logic req_r,
  input  logic pop,
  output logic issue,
  output logic ack_r,
  output logic served
);
  assign issue = avail & req_r & ~served & ~ack_r;

  // Pulse ack for one cycle; remember the head was delivered until it pops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_r  <= 1'b0;
      served <= 1'b0;
    end else begin
      ack_r  <= issue;
      served <= pop ? 1'b0 : (served | issue);
    end
  end
endmodule

module elastic_async_operator #(
  parameter int    data_width  = 32,
  parameter string op          = "reg",
  parameter int    immediate   = 0,
  parameter int    input_size  = 1,
  parameter int    output_size = 1,
  parameter int    depth       = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [input_size-1:0]            req_l,
  input  logic [input_size-1:0]            ack_l,
  input  logic [data_width*input_size-1:0] din,
  input  logic [output_size-1:0]           req_r,
  output logic [output_size-1:0]           ack_r,
  output logic [data_width-1:0]            dout,
  output logic [$clog2(depth):0]           level
`ifdef ELASTIC_OP_STATS_EN
  ,
  output logic [31:0]                      fire_cnt,
  output logic [31:0]                      stall_cnt
`endif
);
  localparam int AW = $clog2(depth);
  localparam logic [AW:0] FULL = depth[AW:0];
  localparam logic [data_width-1:0] IMM = data_width'(immediate);

  // Pass-through and immediate forms take exactly one operand. The folding
  // forms need at least two. Any other combination yields a constant 0.
  localparam bit IS_PASS = (op == "reg") || (op == "in") || (op == "out");
  localparam int OP_NONE = 0, OP_PASS = 1, OP_ADD = 2, OP_SUB = 3, OP_MUL = 4,
                 OP_ADDI = 5, OP_SUBI = 6, OP_MULI = 7;
  localparam int OPC =
    (IS_PASS        && input_size == 1) ? OP_PASS :
    (op == "add"    && input_size >= 2) ? OP_ADD  :
    (op == "sub"    && input_size >= 2) ? OP_SUB  :
    (op == "mul"    && input_size >= 2) ? OP_MUL  :
    (op == "addi"   && input_size == 1) ? OP_ADDI :
    (op == "subi"   && input_size == 1) ? OP_SUBI :
    (op == "muli"   && input_size == 1) ? OP_MULI : OP_NONE;

  logic [input_size-1:0]                  has;
  logic [input_size-1:0][data_width-1:0]  opnd;
  logic [output_size-1:0]                 issue, served;
  logic                                   fire, pop;
  logic [data_width-1:0]                  result;
  logic [data_width-1:0]                  mem [depth];
  logic [AW-1:0]                          wr_ptr, rd_ptr;

  for (genvar i = 0; i < input_size; i++) begin : g_in
    elastic_async_operator_slot #(.data_width(data_width)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .ack_l (ack_l[i]),
      .din   (din[data_width*i +: data_width]),
      .fire  (fire),
      .req_l (req_l[i]),
      .has   (has[i]),
      .opnd  (opnd[i])
    );
  end

  for (genvar j = 0; j < output_size; j++) begin : g_out
    elastic_async_operator_port u_port (
      .clk    (clk),
      .rst    (rst),
      .avail  (level != '0),
      .req_r  (req_r[j]),
      .pop    (pop),
      .issue  (issue[j]),
      .ack_r  (ack_r[j]),
      .served (served[j])
    );
  end

  // Pop once every consumer holds the head, counting acks issued this edge.
  // A full FIFO may still accept a push on the same edge it pops.
  assign pop  = (level != '0) & (&(served | issue));
  assign fire = (&has) & ((level != FULL) | pop);

  // Left fold of the operands, truncated to data_width
  always_comb begin
    result = '0;
    case (OPC)
      OP_PASS: result = opnd[0];
      OP_ADD:  begin
        result = opnd[0];
        for (int i = 1; i < input_size; i++) result = result + opnd[i];
      end
      OP_SUB:  begin
        result = opnd[0];
        for (int i = 1; i < input_size; i++) result = result - opnd[i];
      end
      OP_MUL:  begin
        result = opnd[0];
        for (int i = 1; i < input_size; i++) result = result * opnd[i];
      end
      OP_ADDI: result = opnd[0] + IMM;
      OP_SUBI: result = opnd[0] - IMM;
      OP_MULI: result = opnd[0] * IMM;
      default: result = '0;
    endcase
  end

  // Result storage; stale contents are harmless because pointers reset
  always_ff @(posedge clk) begin
    if (fire) mem[wr_ptr] <= result;
  end

  // FIFO pointers, occupancy and the registered head copy. dout samples the
  // head before any pop on this edge, so it still holds the acknowledged entry
  // during the ack cycle. It then follows the new head, or holds when empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      dout   <= '0;
    end else begin
      if (fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (fire && !pop)      level <= level + 1'b1;
      else if (pop && !fire) level <= level - 1'b1;
      if (level != '0) dout <= mem[rd_ptr];
    end
  end

`ifdef ELASTIC_OP_STATS_EN
  // Results pushed, and cycles where all operands waited on a full FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fire_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (fire)              fire_cnt  <= fire_cnt + 32'd1;
      if ((&has) && !fire)   stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_elastic_async_operator.sv
// Bench for elastic_async_operator. Four instances cover addi, a two-operand
// add, a two-consumer reg fork with depth 4, and an 8-bit mul. Expected results
// come from in-order queues of what the producers handed in.
module tb_elastic_async_operator;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- instance A: addi imm=2, in=1, out=1, depth=2
  logic [0:0]  a_req_l, a_ack_r;
  logic [0:0]  a_ack_l = 1'b0, a_req_r = 1'b0;
  logic [31:0] a_din = '0, a_dout;
  logic [1:0]  a_level;
  // ---------------- instance B: add, in=2
  logic [1:0]  b_req_l, b_level;
  logic        b_ack0 = 1'b0, b_ack1 = 1'b0;
  logic [31:0] b_d0 = '0, b_d1 = '0, b_dout;
  logic [0:0]  b_req_r = 1'b0, b_ack_r;
  // ---------------- instance C: reg, out=2, depth=4
  logic [0:0]  c_req_l;
  logic [0:0]  c_ack_l = 1'b0;
  logic [31:0] c_din = '0, c_dout;
  logic [1:0]  c_req_r = 2'b00, c_ack_r;
  logic [2:0]  c_level;
  // ---------------- instance D: mul, data_width=8, in=2
  logic [1:0]  d_req_l, d_level;
  logic [1:0]  d_ack_l = 2'b00;
  logic [15:0] d_din = '0;
  logic [0:0]  d_req_r = 1'b0, d_ack_r;
  logic [7:0]  d_dout;
`ifdef ELASTIC_OP_STATS_EN
  logic [31:0] a_fc, a_sc, b_fc, b_sc, c_fc, c_sc, d_fc, d_sc;
`endif

  elastic_async_operator #(.data_width(32), .op("addi"), .immediate(2),
    .input_size(1), .output_size(1), .depth(2)) u_a (
    .clk(clk), .rst(rst_n), .req_l(a_req_l), .ack_l(a_ack_l), .din(a_din),
    .req_r(a_req_r), .ack_r(a_ack_r), .dout(a_dout), .level(a_level)
`ifdef ELASTIC_OP_STATS_EN
    , .fire_cnt(a_fc), .stall_cnt(a_sc)
`endif
  );

  elastic_async_operator #(.data_width(32), .op("add"), .immediate(0),
    .input_size(2), .output_size(1), .depth(2)) u_b (
    .clk(clk), .rst(rst_n), .req_l(b_req_l), .ack_l({b_ack1, b_ack0}), .din({b_d1, b_d0}),
    .req_r(b_req_r), .ack_r(b_ack_r), .dout(b_dout), .level(b_level)
`ifdef ELASTIC_OP_STATS_EN
    , .fire_cnt(b_fc), .stall_cnt(b_sc)
`endif
  );

  elastic_async_operator #(.data_width(32), .op("reg"), .immediate(0),
    .input_size(1), .output_size(2), .depth(4)) u_c (
    .clk(clk), .rst(rst_n), .req_l(c_req_l), .ack_l(c_ack_l), .din(c_din),
    .req_r(c_req_r), .ack_r(c_ack_r), .dout(c_dout), .level(c_level)
`ifdef ELASTIC_OP_STATS_EN
    , .fire_cnt(c_fc), .stall_cnt(c_sc)
`endif
  );

  elastic_async_operator #(.data_width(8), .op("mul"), .immediate(0),
    .input_size(2), .output_size(1), .depth(2)) u_d (
    .clk(clk), .rst(rst_n), .req_l(d_req_l), .ack_l(d_ack_l), .din(d_din),
    .req_r(d_req_r), .ack_r(d_ack_r), .dout(d_dout), .level(d_level)
`ifdef ELASTIC_OP_STATS_EN
    , .fire_cnt(d_fc), .stall_cnt(d_sc)
`endif
  );

  // ---------------- reference model: in-order expected results per instance
  logic [31:0] a_seq[$];
  logic [31:0] b_va[$], b_vb[$];
  logic [31:0] c_seq[$];
  int a_idx = 0, b_idx = 0;
  int c_idx [2] = '{0, 0};
  bit a_mon = 0, b_mon = 0, c_mon = 0;
  int a_t0 = -1, a_first_ack = -1;
  logic [31:0] b_exp;

  always @(negedge clk) if (a_mon && a_ack_r[0]) begin
    if (a_idx == 0) a_first_ack = cyc;
    if (a_idx < a_seq.size()) chk("a_dout", a_dout, a_seq[a_idx]);
    else chk("a_extra_ack", 1, 0);
    a_idx++;
  end

  always @(negedge clk) if (b_mon && b_ack_r[0]) begin
    if (b_idx < b_va.size() && b_idx < b_vb.size()) begin
      b_exp = b_va[b_idx] + b_vb[b_idx];
      chk("b_dout", b_dout, b_exp);
    end else chk("b_extra_ack", 1, 0);
    b_idx++;
  end

  always @(negedge clk) if (c_mon) begin
    for (int j = 0; j < 2; j++) if (c_ack_r[j]) begin
      if (c_idx[j] < c_seq.size()) chk($sformatf("c_dout_cons%0d", j), c_dout, c_seq[c_idx[j]]);
      else chk($sformatf("c_extra_ack_cons%0d", j), 1, 0);
      c_idx[j]++;
    end
    if (c_level > 3'd4) chk("c_level_bound", c_level, 4);
  end

  // ---------------- producer helpers (entered and left on a negedge)
  task automatic a_put(input logic [31:0] v);
    bit ok = 0;
    logic [31:0] e;
    for (int t = 0; t < 100 && !ok; t++) if (a_req_l[0]) ok = 1; else @(negedge clk);
    if (!ok) chk("a_req_l_timeout", 0, 1);
    e = v + 32'd2;
    a_seq.push_back(e);
    if (a_t0 < 0) a_t0 = cyc;
    a_ack_l = 1'b1; a_din = v;
    @(negedge clk);
    a_ack_l = 1'b0;
  endtask

  task automatic b_put(input int i, input logic [31:0] v);
    bit ok = 0;
    for (int t = 0; t < 300 && !ok; t++) if (b_req_l[i]) ok = 1; else @(negedge clk);
    if (!ok) chk("b_req_l_timeout", 0, 1);
    if (i == 0) begin b_ack0 = 1'b1; b_d0 = v; b_va.push_back(v); end
    else        begin b_ack1 = 1'b1; b_d1 = v; b_vb.push_back(v); end
    @(negedge clk);
    if (i == 0) b_ack0 = 1'b0; else b_ack1 = 1'b0;
  endtask

  task automatic c_put(input logic [31:0] v);
    bit ok = 0;
    for (int t = 0; t < 300 && !ok; t++) if (c_req_l[0]) ok = 1; else @(negedge clk);
    if (!ok) chk("c_req_l_timeout", 0, 1);
    c_seq.push_back(v);
    c_ack_l = 1'b1; c_din = v;
    @(negedge clk);
    c_ack_l = 1'b0;
  endtask

  task automatic c_wait_level(input logic [2:0] lv);
    bit ok = 0;
    for (int t = 0; t < 50 && !ok; t++) if (c_level == lv) ok = 1; else @(negedge clk);
    if (!ok) chk("c_level_wait", c_level, lv);
  endtask

  task automatic c_wait_drain(input string name);
    bit ok = 0;
    for (int t = 0; t < 3000 && !ok; t++)
      if (c_idx[0] == c_seq.size() && c_idx[1] == c_seq.size()) ok = 1; else @(negedge clk);
    chk(name, ok, 1);
  endtask

  typedef struct { logic [7:0] a; logic [7:0] b; logic [7:0] exp; } mul_vec_t;
  mul_vec_t mv [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok, low;
    int n;
    mv[0] = '{8'h20, 8'h10, 8'h00};
    mv[1] = '{8'h03, 8'h05, 8'h0f};
    mv[2] = '{8'hff, 8'hff, 8'h01};
    mv[3] = '{8'h10, 8'h11, 8'h10};
    mv[4] = '{8'h0f, 8'h11, 8'hff};
    mv[5] = '{8'h07, 8'h00, 8'h00};
    mv[6] = '{8'h81, 8'h02, 8'h02};

    // ---- reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_a_req_l", a_req_l, 0);
    chk("rst_a_ack_r", a_ack_r, 0);
    chk("rst_a_level", a_level, 0);
    chk("rst_a_dout",  a_dout, 0);
    chk("rst_c_ack_r", c_ack_r, 0);
    chk("rst_b_req_l", b_req_l, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_a_req_l", a_req_l, 1);

    // ---- 1: addi stream 0..9, latency of the first result
    a_mon = 1; a_req_r = 1'b1;
    for (int k = 0; k < 10; k++) a_put(32'(k));
    ok = 0;
    for (int t = 0; t < 100 && !ok; t++) if (a_idx == 10) ok = 1; else @(negedge clk);
    chk("a_stream_count", a_idx, 10);
    chk("a_first_latency", a_first_ack - (a_t0 + 1), 2);
    a_mon = 0; a_req_r = 1'b0;

    // ---- 2: add with the second operand 5 cycles late
    b_mon = 1; b_req_r = 1'b1;
    b_put(0, 32'd7);
    low = 1;
    for (int t = 0; t < 4; t++) begin
      if (b_req_l[0] !== 1'b0) low = 0;
      if (b_ack_r[0] !== 1'b0) low = 0;
      @(negedge clk);
    end
    chk("b_req_l0_held_low", low, 1);
    b_put(1, 32'd3);
    repeat (8) @(negedge clk);
    chk("b_single_ack", b_idx, 1);
    chk("b_dout_sum", b_dout, 10);

    // ---- B random: independent operand rates, random consumer
    fork
      for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        b_put(0, $urandom());
      end
      for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        b_put(1, $urandom());
      end
      begin
        ok = 0;
        for (int t = 0; t < 3000 && !ok; t++) begin
          if (b_idx == 26) ok = 1;
          else begin b_req_r = 1'($urandom_range(0, 1)); @(negedge clk); end
        end
        chk("b_rand_drain", ok, 1);
      end
    join
    b_req_r = 1'b0; b_mon = 0;

    // ---- 4: 8-bit mul table
    d_req_r = 1'b1;
    foreach (mv[i]) begin
      ok = 0;
      for (int t = 0; t < 50 && !ok; t++) if (d_req_l == 2'b11) ok = 1; else @(negedge clk);
      if (!ok) chk("d_req_l_timeout", 0, 1);
      d_ack_l = 2'b11; d_din = {mv[i].b, mv[i].a};
      @(negedge clk);
      d_ack_l = 2'b00;
      ok = 0;
      for (int t = 0; t < 10 && !ok; t++) if (d_ack_r[0]) ok = 1; else @(negedge clk);
      if (!ok) chk("d_ack_r_timeout", 0, 1);
      else chk($sformatf("d_mul_%0d", i), d_dout, mv[i].exp);
    end
    d_req_r = 1'b0;

    // ---- 3: slow consumer 1 fills the FIFO, then drains
    c_mon = 1; c_req_r = 2'b01;
    for (int k = 0; k < 4; k++) c_put(32'(k));
    c_wait_level(3'd4);
    c_put(32'd4);
    repeat (6) @(negedge clk);
    chk("c_full_level", c_level, 4);
    chk("c_full_req_l_held", c_req_l, 0);
    chk("c_cons0_saw_one", c_idx[0], 1);
    chk("c_cons1_saw_none", c_idx[1], 0);
`ifdef ELASTIC_OP_STATS_EN
    chk("c_stall_cnt_blocked", c_sc, 6);
    chk("c_fire_cnt_blocked", c_fc, 4);
`endif
    c_req_r = 2'b11;
    c_wait_drain("c_drain_3");
    chk("c_level_empty_3", c_level, 0);
`ifdef ELASTIC_OP_STATS_EN
    chk("c_stall_cnt_final", c_sc, 6);
    chk("c_fire_cnt_final", c_fc, 5);
`endif

    // ---- 5: full FIFO, both consumers ack on the edge a fire is ready
    c_req_r = 2'b00;
    for (int k = 10; k < 14; k++) c_put(32'(k));
    c_wait_level(3'd4);
    c_put(32'd14);
    @(negedge clk);
    c_req_r = 2'b11;
    @(negedge clk);
    chk("c_pushpop_ack", c_ack_r, 2'b11);
    chk("c_pushpop_level", c_level, 4);
    c_wait_drain("c_drain_5");
    chk("c_level_empty_5", c_level, 0);

    // ---- C random: random consumer requests, random producer gaps
    fork
      for (int k = 0; k < 30; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        c_put($urandom());
      end
      for (int t = 0; t < 600; t++) begin
        c_req_r = 2'($urandom_range(0, 3));
        @(negedge clk);
      end
    join
    c_req_r = 2'b11;
    c_wait_drain("c_rand_drain");
    c_req_r = 2'b00; c_mon = 0;

    // ---- 6: reset with two entries held in A
    a_put(32'd100);
    a_put(32'd101);
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) if (a_level == 2'd2) ok = 1; else @(negedge clk);
    chk("a_two_held", a_level, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst6_a_level", a_level, 0);
    chk("rst6_a_dout",  a_dout, 0);
    chk("rst6_a_req_l", a_req_l, 0);
    chk("rst6_a_ack_r", a_ack_r, 0);
`ifdef ELASTIC_OP_STATS_EN
    chk("rst6_a_fire_cnt", a_fc, 0);
    chk("rst6_c_stall_cnt", c_sc, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst6_a_req_l_back", a_req_l, 1);
    chk("rst6_b_req_l_back", b_req_l, 2'b11);
    a_req_r = 1'b1;
    n = 0;
    for (int t = 0; t < 6; t++) begin
      if (a_ack_r[0]) n++;
      @(negedge clk);
    end
    chk("rst6_data_discarded", n, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
